// File: rtl/avl_arb_pkg.sv
// Shared types for the two-master Avalon-MM arbiter: master identifiers
// and the default tag counter width.
package avl_arb_pkg;

  typedef enum logic {
    ID_ISTR = 1'b0,
    ID_DATA = 1'b1
  } master_id_t;

  localparam int MAX_PENDING_DEF = 4;
  localparam int TAG_CNT_W       = $clog2(MAX_PENDING_DEF) + 1;

endpackage

// File: rtl/i_avl_bus.sv
// Pipelined Avalon-MM bus bundle; `master` drives commands, `slave` answers.
interface i_avl_bus #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/avl_tag_fifo.sv
// Small synchronous FIFO of master ids; records which master owns each
// outstanding read so responses can be routed back in order.
module avl_tag_fifo
  import avl_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rest,
  input  logic                   push,
  input  master_id_t             push_id,
  input  logic                   pop,
  output master_id_t             head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  master_id_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot being written.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/avl_arbiter_2to1.sv
// Round-robin merge of the instruction and data Avalon-MM masters onto one
// slave port, with in-order read response routing via a tag FIFO.
module avl_arbiter_2to1
  import avl_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_PENDING = 4
) (
  input  logic     clk,
  input  logic     rest,
  i_avl_bus.slave  avl_s0,
  i_avl_bus.slave  avl_s1,
  i_avl_bus.master avl_m0,
  output logic     err_orphan
);

  localparam int CNT_W = $clog2(MAX_PENDING) + 1;

  logic                req0;
  logic                req1;
  logic                grant_vld;
  master_id_t          grant;
  logic                lock;
  master_id_t          lock_id;
  master_id_t          last_id;

  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [DATA_W/8-1:0] sel_be;
  logic                sel_rd;
  logic                sel_wr;

  logic                read_block;
  logic                stall;
  logic                accept;

  logic                tag_push;
  logic                tag_pop;
  master_id_t          tag_head;
  logic                tag_full;
  logic                tag_empty;
  logic [CNT_W-1:0]    tag_count;

  assign req0 = avl_s0.read | avl_s0.write;
  assign req1 = avl_s1.read | avl_s1.write;

  always_comb begin
    grant_vld = 1'b0;
    grant     = ID_ISTR;
    if (lock) begin
      grant_vld = 1'b1;
      grant     = lock_id;
    end else if (req0 && req1) begin
      grant_vld = 1'b1;
      grant     = (last_id == ID_ISTR) ? ID_DATA : ID_ISTR;
    end else if (req0) begin
      grant_vld = 1'b1;
      grant     = ID_ISTR;
    end else if (req1) begin
      grant_vld = 1'b1;
      grant     = ID_DATA;
    end
  end

  // Idle bus still carries input 0's address/data; only read/write are gated.
  always_comb begin
    sel_addr  = avl_s0.address;
    sel_wdata = avl_s0.writedata;
    sel_be    = avl_s0.byteenable;
    sel_rd    = 1'b0;
    sel_wr    = 1'b0;
    if (grant_vld) begin
      if (grant == ID_DATA) begin
        sel_addr  = avl_s1.address;
        sel_wdata = avl_s1.writedata;
        sel_be    = avl_s1.byteenable;
        sel_rd    = avl_s1.read;
        sel_wr    = avl_s1.write;
      end else begin
        sel_rd    = avl_s0.read;
        sel_wr    = avl_s0.write;
      end
    end
  end

  // Full is taken before any same-cycle pop, keeping readdatavalid off the
  // waitrequest path.
  assign read_block = sel_rd & tag_full;
  assign stall      = avl_m0.waitrequest | read_block;
  assign accept     = (sel_rd | sel_wr) & ~stall;

  assign avl_m0.address    = sel_addr;
  assign avl_m0.writedata  = sel_wdata;
  assign avl_m0.byteenable = sel_be;
  assign avl_m0.read       = sel_rd & ~read_block;
  assign avl_m0.write      = sel_wr;

  assign avl_s0.waitrequest = ~(grant_vld & (grant == ID_ISTR)) | stall;
  assign avl_s1.waitrequest = ~(grant_vld & (grant == ID_DATA)) | stall;

  assign tag_push = accept & sel_rd;
  assign tag_pop  = avl_m0.readdatavalid & ~tag_empty;

  assign avl_s0.readdata      = avl_m0.readdata;
  assign avl_s1.readdata      = avl_m0.readdata;
  assign avl_s0.readdatavalid = tag_pop & (tag_head == ID_ISTR);
  assign avl_s1.readdatavalid = tag_pop & (tag_head == ID_DATA);

  // Lock keeps a stalled command on the bus until it is taken, so the slave
  // never sees it swapped for the other master's command.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      lock       <= 1'b0;
      lock_id    <= ID_ISTR;
      last_id    <= ID_DATA;
      err_orphan <= 1'b0;
    end else begin
      lock <= (sel_rd | sel_wr) & stall;
      if ((sel_rd | sel_wr) & stall) lock_id <= grant;
      if (accept) last_id <= grant;
      if (avl_m0.readdatavalid & tag_empty) err_orphan <= 1'b1;
    end
  end

  avl_tag_fifo #(
    .DEPTH (MAX_PENDING)
  ) u_tag_fifo (
    .clk     (clk),
    .rest    (rest),
    .push    (tag_push),
    .push_id (grant),
    .pop     (tag_pop),
    .head    (tag_head),
    .full    (tag_full),
    .empty   (tag_empty),
    .count   (tag_count)
  );

  a_tag_bound: assert property (@(posedge clk) disable iff (!rest)
    tag_count <= CNT_W'(MAX_PENDING));

endmodule

// File: tb/tb_avl_arbiter_2to1.sv
// Scenario and randomized checks of avl_arbiter_2to1 against a queue-based
// model of the arbitration and response-routing rules.
module tb_avl_arbiter_2to1;
  import avl_arb_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXP = 4;

  logic clk = 1'b0;
  logic rest;
  logic err_orphan;

  i_avl_bus #(.ADDR_W(AW), .DATA_W(DW)) bs0 ();
  i_avl_bus #(.ADDR_W(AW), .DATA_W(DW)) bs1 ();
  i_avl_bus #(.ADDR_W(AW), .DATA_W(DW)) bm0 ();

  avl_arbiter_2to1 #(.ADDR_W(AW), .DATA_W(DW), .MAX_PENDING(MAXP)) dut (
    .clk        (clk),
    .rest       (rest),
    .avl_s0     (bs0),
    .avl_s1     (bs1),
    .avl_m0     (bm0),
    .err_orphan (err_orphan)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int m_last;
  bit m_lock;
  int m_lock_id;
  int tagq[$];
  bit m_orphan;
  // Model outputs for the current cycle
  bit e_gv, e_rd, e_wr, e_wait0, e_wait1, e_rdv0, e_rdv1, e_acc, e_push, e_stall_cmd;
  int e_g;

  function automatic void model_reset();
    tagq.delete();
    m_last = 1; m_lock = 0; m_lock_id = 0; m_orphan = 0;
  endfunction

  function automatic void model_eval();
    bit r0, r1, gr, gw, full, blocked;
    r0 = bs0.read | bs0.write;
    r1 = bs1.read | bs1.write;
    e_gv = 0; e_g = 0;
    if (m_lock) begin e_gv = 1; e_g = m_lock_id; end
    else if (r0 && r1) begin e_gv = 1; e_g = (m_last == 0) ? 1 : 0; end
    else if (r0) begin e_gv = 1; e_g = 0; end
    else if (r1) begin e_gv = 1; e_g = 1; end
    gr = e_gv && ((e_g == 1) ? bs1.read : bs0.read);
    gw = e_gv && ((e_g == 1) ? bs1.write : bs0.write);
    full = (tagq.size() >= MAXP);
    blocked = gr && full;
    e_rd = gr && !full;
    e_wr = gw;
    e_wait0 = !(e_gv && e_g == 0) || bm0.waitrequest || blocked;
    e_wait1 = !(e_gv && e_g == 1) || bm0.waitrequest || blocked;
    e_acc = (gr || gw) && !bm0.waitrequest && !blocked;
    e_push = e_acc && gr;
    e_stall_cmd = (gr || gw) && !e_acc;
    e_rdv0 = bm0.readdatavalid && (tagq.size() > 0) && (tagq[0] == 0);
    e_rdv1 = bm0.readdatavalid && (tagq.size() > 0) && (tagq[0] == 1);
  endfunction

  // Clock one cycle and apply the model's state update
  task automatic advance();
    bit was_empty;
    bit rdv;
    model_eval();
    was_empty = (tagq.size() == 0);
    rdv = bm0.readdatavalid;
    @(posedge clk);
    if (rdv && !was_empty) void'(tagq.pop_front());
    if (rdv && was_empty) m_orphan = 1;
    if (e_acc) m_last = e_g;
    if (e_push) tagq.push_back(e_g);
    m_lock = e_stall_cmd;
    m_lock_id = e_g;
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bs0.read = 0; bs0.write = 0; bs0.address = '0; bs0.writedata = '0; bs0.byteenable = '1;
    bs1.read = 0; bs1.write = 0; bs1.address = '0; bs1.writedata = '0; bs1.byteenable = '1;
    bm0.waitrequest = 0; bm0.readdatavalid = 0; bm0.readdata = '0;
  endtask

  task automatic apply_reset(input int ncyc);
    rest = 1'b0;
    model_reset();
    repeat (ncyc) @(negedge clk);
    rest = 1'b1;
  endtask

  task automatic test_reset();
    drive_idle();
    rest = 1'b1;
    #2 rest = 1'b0;
    model_reset();
    @(negedge clk); #1;
    n_cmp++; if (bm0.read !== 1'b0) begin n_bad++; $display("FAIL reset_m0_read: got %b want 0", bm0.read); end
    n_cmp++; if (bm0.write !== 1'b0) begin n_bad++; $display("FAIL reset_m0_write: got %b want 0", bm0.write); end
    n_cmp++; if (err_orphan !== 1'b0) begin n_bad++; $display("FAIL reset_orphan: got %b want 0", err_orphan); end
    bm0.readdatavalid = 1; #1;
    n_cmp++; if (bs0.readdatavalid !== 1'b0) begin n_bad++; $display("FAIL reset_s0_rdv: got %b want 0", bs0.readdatavalid); end
    n_cmp++; if (bs1.readdatavalid !== 1'b0) begin n_bad++; $display("FAIL reset_s1_rdv: got %b want 0", bs1.readdatavalid); end
    bm0.readdatavalid = 0;
    @(negedge clk);
    rest = 1'b1;
  endtask

  task automatic test_single_read();
    logic [DW-1:0] data;
    int rdv0_cnt, rdv1_cnt, rd_cnt;
    data = $urandom;
    drive_idle();
    bs0.read = 1; bs0.address = 32'h100;
    #1;
    n_cmp++; if (bm0.read !== 1'b1) begin n_bad++; $display("FAIL single_m0_read: got %b want 1", bm0.read); end
    n_cmp++; if (bm0.address !== 32'h100) begin n_bad++; $display("FAIL single_addr: got %h want 00000100", bm0.address); end
    n_cmp++; if (bs0.waitrequest !== 1'b0) begin n_bad++; $display("FAIL single_s0_wait: got %b want 0", bs0.waitrequest); end
    advance();
    bs0.read = 0;
    rdv0_cnt = 0; rdv1_cnt = 0; rd_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      bm0.readdatavalid = (c == 2);
      bm0.readdata = (c == 2) ? data : '0;
      #1;
      rd_cnt += int'(bm0.read);
      rdv0_cnt += int'(bs0.readdatavalid);
      rdv1_cnt += int'(bs1.readdatavalid);
      if (c == 2) begin
        n_cmp++; if (bs0.readdata !== data) begin n_bad++; $display("FAIL single_rdata: got %h want %h", bs0.readdata, data); end
      end
      advance();
    end
    bm0.readdatavalid = 0;
    n_cmp++; if (rdv0_cnt != 1) begin n_bad++; $display("FAIL single_s0_rdv_count: got %0d want 1", rdv0_cnt); end
    n_cmp++; if (rdv1_cnt != 0) begin n_bad++; $display("FAIL single_s1_rdv_count: got %0d want 0", rdv1_cnt); end
    n_cmp++; if (rd_cnt != 0) begin n_bad++; $display("FAIL single_extra_reads: got %0d want 0", rd_cnt); end
  endtask

  task automatic test_alternate();
    int exp_ids[$];
    int avail, n0, n1, want, id;
    logic [AW-1:0] exp_addr;
    drive_idle();
    apply_reset(2);
    n0 = 0; n1 = 0; avail = 0;
    bs0.read = 1; bs0.address = 32'h1000;
    bs1.read = 1; bs1.address = 32'h2000;
    for (int k = 0; k < 8; k++) begin
      want = k % 2;
      bm0.readdatavalid = (avail > 0);
      bm0.readdata = $urandom;
      #1;
      exp_addr = (want == 1) ? (32'h2000 + AW'(4 * n1)) : (32'h1000 + AW'(4 * n0));
      n_cmp++; if (bs0.waitrequest !== (want != 0)) begin n_bad++; $display("FAIL alt_s0_wait k%0d: got %b want %b", k, bs0.waitrequest, want != 0); end
      n_cmp++; if (bs1.waitrequest !== (want == 0)) begin n_bad++; $display("FAIL alt_s1_wait k%0d: got %b want %b", k, bs1.waitrequest, want == 0); end
      n_cmp++; if (bm0.address !== exp_addr) begin n_bad++; $display("FAIL alt_addr k%0d: got %h want %h", k, bm0.address, exp_addr); end
      if (avail > 0) begin
        id = exp_ids.pop_front();
        avail--;
        n_cmp++; if (bs0.readdatavalid !== (id == 0) || bs1.readdatavalid !== (id == 1)) begin
          n_bad++; $display("FAIL alt_route k%0d: got s0=%b s1=%b want id %0d", k, bs0.readdatavalid, bs1.readdatavalid, id);
        end
      end
      exp_ids.push_back(want);
      avail++;
      advance();
      if (want == 0) begin n0++; bs0.address = 32'h1000 + AW'(4 * n0); end
      else begin n1++; bs1.address = 32'h2000 + AW'(4 * n1); end
    end
    bs0.read = 0; bs1.read = 0;
    for (int g = 0; g < 10 && exp_ids.size() > 0; g++) begin
      bm0.readdatavalid = 1;
      #1;
      id = exp_ids.pop_front();
      n_cmp++; if (bs0.readdatavalid !== (id == 0) || bs1.readdatavalid !== (id == 1)) begin
        n_bad++; $display("FAIL alt_drain_route: got s0=%b s1=%b want id %0d", bs0.readdatavalid, bs1.readdatavalid, id);
      end
      advance();
    end
    bm0.readdatavalid = 0;
  endtask

  task automatic test_lock();
    int wr_acc;
    drive_idle();
    apply_reset(2);
    wr_acc = 0;
    bs1.write = 1; bs1.address = 32'h3000; bs1.writedata = 32'hDEADBEEF;
    bs0.address = 32'h4000;
    for (int c = 0; c < 7; c++) begin
      bm0.waitrequest = (c < 5);
      bs0.read = (c >= 2);
      #1;
      if (c <= 5) begin
        n_cmp++; if (bm0.write !== 1'b1 || bm0.address !== 32'h3000 || bm0.writedata !== 32'hDEADBEEF) begin
          n_bad++; $display("FAIL lock_hold c%0d: got wr=%b addr=%h wd=%h want 1 3000 deadbeef", c, bm0.write, bm0.address, bm0.writedata);
        end
        n_cmp++; if (bs1.waitrequest !== (c < 5)) begin n_bad++; $display("FAIL lock_s1_wait c%0d: got %b want %b", c, bs1.waitrequest, c < 5); end
        n_cmp++; if (bs0.waitrequest !== 1'b1) begin n_bad++; $display("FAIL lock_s0_wait c%0d: got %b want 1", c, bs0.waitrequest); end
      end else begin
        n_cmp++; if (bm0.read !== 1'b1 || bm0.write !== 1'b0 || bm0.address !== 32'h4000 || bs0.waitrequest !== 1'b0) begin
          n_bad++; $display("FAIL lock_after: got rd=%b wr=%b addr=%h s0wait=%b want 1 0 4000 0", bm0.read, bm0.write, bm0.address, bs0.waitrequest);
        end
      end
      wr_acc += int'(bm0.write & ~bm0.waitrequest);
      advance();
      if (c == 5) bs1.write = 0;
    end
    bs0.read = 0;
    n_cmp++; if (wr_acc != 1) begin n_bad++; $display("FAIL lock_write_count: got %0d want 1", wr_acc); end
    bm0.readdatavalid = 1;
    #1;
    n_cmp++; if (bs0.readdatavalid !== 1'b1 || bs1.readdatavalid !== 1'b0) begin
      n_bad++; $display("FAIL lock_resp: got s0=%b s1=%b want 1 0", bs0.readdatavalid, bs1.readdatavalid);
    end
    advance();
    bm0.readdatavalid = 0;
  endtask

  task automatic test_full_block();
    bit rdv_t [11] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0};
    bit wait_t[11] = '{0, 0, 0, 0, 1, 1, 1, 0, 1, 1, 0};
    int n;
    logic [AW-1:0] exp_addr;
    drive_idle();
    apply_reset(2);
    n = 0;
    bs0.read = 1; bs0.address = 32'h5000;
    for (int c = 0; c < 11; c++) begin
      bm0.readdatavalid = rdv_t[c];
      #1;
      if (c == 6) begin
        n_cmp++; if (n != 4) begin n_bad++; $display("FAIL full_accepted: got %0d want 4", n); end
      end
      n_cmp++; if (bs0.waitrequest !== wait_t[c]) begin n_bad++; $display("FAIL full_s0_wait c%0d: got %b want %b", c, bs0.waitrequest, wait_t[c]); end
      n_cmp++; if (bm0.read !== !wait_t[c]) begin n_bad++; $display("FAIL full_m0_read c%0d: got %b want %b", c, bm0.read, !wait_t[c]); end
      n_cmp++; if (bs0.readdatavalid !== rdv_t[c]) begin n_bad++; $display("FAIL full_s0_rdv c%0d: got %b want %b", c, bs0.readdatavalid, rdv_t[c]); end
      if (!wait_t[c]) begin
        exp_addr = 32'h5000 + AW'(4 * n);
        n_cmp++; if (bm0.address !== exp_addr) begin n_bad++; $display("FAIL full_addr c%0d: got %h want %h", c, bm0.address, exp_addr); end
      end
      advance();
      if (!wait_t[c]) begin n++; bs0.address = 32'h5000 + AW'(4 * n); end
    end
    bs0.read = 0;
    for (int g = 0; g < 10 && tagq.size() > 0; g++) begin
      bm0.readdatavalid = 1;
      #1;
      n_cmp++; if (bs0.readdatavalid !== 1'b1 || bs1.readdatavalid !== 1'b0) begin
        n_bad++; $display("FAIL full_drain: got s0=%b s1=%b want 1 0", bs0.readdatavalid, bs1.readdatavalid);
      end
      advance();
    end
    bm0.readdatavalid = 0;
  endtask

  task automatic test_orphan();
    drive_idle();
    bm0.readdatavalid = 1; bm0.readdata = $urandom;
    #1;
    n_cmp++; if (bs0.readdatavalid !== 1'b0 || bs1.readdatavalid !== 1'b0) begin
      n_bad++; $display("FAIL orphan_rdv: got s0=%b s1=%b want 0 0", bs0.readdatavalid, bs1.readdatavalid);
    end
    n_cmp++; if (err_orphan !== 1'b0) begin n_bad++; $display("FAIL orphan_early: got %b want 0", err_orphan); end
    advance();
    bm0.readdatavalid = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (err_orphan !== 1'b1) begin n_bad++; $display("FAIL orphan_sticky c%0d: got %b want 1", c, err_orphan); end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    drive_idle();
    apply_reset(2);
    #1;
    n_cmp++; if (err_orphan !== 1'b0) begin n_bad++; $display("FAIL rmid_orphan_clear: got %b want 0", err_orphan); end
    for (int i = 0; i < 3; i++) begin
      bs0.read = 1; bs0.address = 32'h6000 + AW'(4 * i);
      advance();
    end
    bs0.address = 32'h7000;
    bs1.read = 1; bs1.address = 32'h7100;
    apply_reset(2);
    bm0.readdatavalid = 1;
    #1;
    n_cmp++; if (bs0.waitrequest !== 1'b0 || bs1.waitrequest !== 1'b1) begin
      n_bad++; $display("FAIL rmid_grant: got s0wait=%b s1wait=%b want 0 1", bs0.waitrequest, bs1.waitrequest);
    end
    n_cmp++; if (bm0.address !== 32'h7000) begin n_bad++; $display("FAIL rmid_addr: got %h want 00007000", bm0.address); end
    n_cmp++; if (bs0.readdatavalid !== 1'b0 || bs1.readdatavalid !== 1'b0) begin
      n_bad++; $display("FAIL rmid_stale_rdv: got s0=%b s1=%b want 0 0", bs0.readdatavalid, bs1.readdatavalid);
    end
    advance();
    bs0.read = 0; bm0.readdatavalid = 0;
    #1;
    n_cmp++; if (err_orphan !== 1'b1) begin n_bad++; $display("FAIL rmid_orphan: got %b want 1", err_orphan); end
    n_cmp++; if (bs1.waitrequest !== 1'b0) begin n_bad++; $display("FAIL rmid_s1_next: got %b want 0", bs1.waitrequest); end
    advance();
    bs1.read = 0;
    for (int k = 0; k < 2; k++) begin
      bm0.readdatavalid = 1;
      #1;
      n_cmp++; if (bs0.readdatavalid !== (k == 0) || bs1.readdatavalid !== (k == 1)) begin
        n_bad++; $display("FAIL rmid_route k%0d: got s0=%b s1=%b", k, bs0.readdatavalid, bs1.readdatavalid);
      end
      advance();
    end
    bm0.readdatavalid = 0;
  endtask

  task automatic test_random();
    bit p_vld[2], p_rd[2];
    logic [AW-1:0] p_addr[2];
    logic [DW-1:0] p_data[2];
    logic [DW/8-1:0] p_be[2];
    int s_pend;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_data;
    drive_idle();
    apply_reset(2);
    s_pend = 0;
    for (int i = 0; i < 2; i++) p_vld[i] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (!p_vld[i] && $urandom_range(0, 2) == 0) begin
          p_vld[i] = 1; p_rd[i] = 1'($urandom_range(0, 1));
          p_addr[i] = $urandom; p_data[i] = $urandom; p_be[i] = 4'($urandom_range(0, 15));
        end
      end
      bs0.read = p_vld[0] & p_rd[0]; bs0.write = p_vld[0] & ~p_rd[0];
      bs0.address = p_addr[0]; bs0.writedata = p_data[0]; bs0.byteenable = p_be[0];
      bs1.read = p_vld[1] & p_rd[1]; bs1.write = p_vld[1] & ~p_rd[1];
      bs1.address = p_addr[1]; bs1.writedata = p_data[1]; bs1.byteenable = p_be[1];
      bm0.waitrequest = ($urandom_range(0, 3) == 0);
      bm0.readdatavalid = (s_pend > 0) && ($urandom_range(0, 2) == 0);
      bm0.readdata = $urandom;
      #1;
      model_eval();
      n_cmp++; if (bm0.read !== e_rd || bm0.write !== e_wr) begin
        n_bad++; $display("FAIL rnd_cmd c%0d: got rd=%b wr=%b want %b %b", cyc, bm0.read, bm0.write, e_rd, e_wr);
      end
      n_cmp++; if (bs0.waitrequest !== e_wait0 || bs1.waitrequest !== e_wait1) begin
        n_bad++; $display("FAIL rnd_wait c%0d: got %b %b want %b %b", cyc, bs0.waitrequest, bs1.waitrequest, e_wait0, e_wait1);
      end
      n_cmp++; if (bs0.readdatavalid !== e_rdv0 || bs1.readdatavalid !== e_rdv1) begin
        n_bad++; $display("FAIL rnd_rdv c%0d: got %b %b want %b %b", cyc, bs0.readdatavalid, bs1.readdatavalid, e_rdv0, e_rdv1);
      end
      n_cmp++; if (err_orphan !== m_orphan) begin n_bad++; $display("FAIL rnd_orphan c%0d: got %b want %b", cyc, err_orphan, m_orphan); end
      if (e_rd || e_wr) begin
        g_addr = p_addr[e_g];
        n_cmp++; if (bm0.address !== g_addr) begin n_bad++; $display("FAIL rnd_addr c%0d: got %h want %h", cyc, bm0.address, g_addr); end
      end
      if (e_wr) begin
        g_data = p_data[e_g];
        n_cmp++; if (bm0.writedata !== g_data || bm0.byteenable !== p_be[e_g]) begin
          n_bad++; $display("FAIL rnd_wdata c%0d: got %h/%h want %h/%h", cyc, bm0.writedata, bm0.byteenable, g_data, p_be[e_g]);
        end
      end
      if (bm0.readdatavalid) begin
        n_cmp++; if (bs0.readdata !== bm0.readdata || bs1.readdata !== bm0.readdata) begin
          n_bad++; $display("FAIL rnd_rdata c%0d: got %h %h want %h", cyc, bs0.readdata, bs1.readdata, bm0.readdata);
        end
        s_pend--;
      end
      if (e_push) s_pend++;
      advance();
      if (e_acc) p_vld[e_g] = 0;
    end
    drive_idle();
    for (int g = 0; g < 20 && s_pend > 0; g++) begin
      bm0.readdatavalid = 1;
      #1;
      model_eval();
      n_cmp++; if (bs0.readdatavalid !== e_rdv0 || bs1.readdatavalid !== e_rdv1) begin
        n_bad++; $display("FAIL rnd_drain: got %b %b want %b %b", bs0.readdatavalid, bs1.readdatavalid, e_rdv0, e_rdv1);
      end
      s_pend--;
      advance();
    end
    bm0.readdatavalid = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_alternate();
    test_lock();
    test_full_block();
    test_orphan();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/avl_arbiter_2to1.md
Name: avl_arbiter_2to1

Overview:
- Merges the core's two Avalon-MM master ports (instruction fetch, data load/store) onto one downstream Avalon-MM slave port.
- Lets a single SDRAM controller or single sdram_sim_model serve both masters.
- Sits directly downstream of core, between core.avl_m0/avl_m1 and the memory.
- Provides round-robin command arbitration and in-order read-response routing through a tag FIFO.

Parameters:
- ADDR_W, 32, address width of all three ports.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- MAX_PENDING, 4, maximum outstanding reads on the slave side; power of two, ≥2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rest  input  1  asynchronous active-low reset.
- avl_s0  i_avl_bus slave side  -  from core avl_m0_istr (instruction master).
- avl_s1  i_avl_bus slave side  -  from core avl_m1_data (data master).
- avl_m0  i_avl_bus master side  -  to the memory/slave.
- err_orphan  output  1  sticky flag: readdatavalid arrived with no outstanding read.
- i_avl_bus signals used: address[ADDR_W], read, write, writedata[DATA_W], byteenable[DATA_W/8], waitrequest, readdata[DATA_W], readdatavalid.

Behaviour:
- Protocol: pipelined Avalon-MM. A command is accepted in a cycle with (read|write) & !waitrequest. Masters hold the command stable while waitrequest=1.
- Grant selection (combinational, from registered state):
  - If lock=1, the grant stays with lock_id.
  - Otherwise, if only one input requests, it wins.
  - If both request, the input ≠ last_id wins.
  - If none request, no grant.
- Forwarding:
  - The granted input's address/writedata/byteenable/read/write drive avl_m0 with zero added latency.
  - With no grant, avl_m0.read=avl_m0.write=0; address/data are don't-care and are driven from input 0.
- Waitrequest back to the masters:
  - Granted input: avl_m0.waitrequest | read_block.
  - Non-granted requesting input: 1.
  - Idle input: 1.
- read_block = granted command is a read and tag FIFO is full. While read_block=1, avl_m0.read is forced to 0.
- Lock register: set when the granted command is presented and stalled (avl_m0.waitrequest=1 or read_block=1); lock_id = grant. Cleared on acceptance. This guarantees a stalled command is never swapped for the other master's command.
- On acceptance: last_id ← grant.
- Tag FIFO (depth MAX_PENDING, 1-bit entries = master id):
  - Push the grant on every accepted read. Writes push nothing.
  - On avl_m0.readdatavalid with FIFO non-empty: pop. The head id selects which avl_sN.readdatavalid pulses, in the same cycle.
  - avl_m0.readdata is broadcast to both avl_s0.readdata and avl_s1.readdata.
  - Simultaneous push and pop is legal at any occupancy, including full.
  - Full is evaluated before the pop, so a pop in the same cycle does not unblock a read (conservative; no combinational path from readdatavalid to waitrequest).
  - avl_m0.readdatavalid with FIFO empty: no pulse to either master; err_orphan←1, held until reset.
- Ordering: responses are strictly in acceptance order; the slave is required to return reads in order.
- Reset (rest=0, asynchronous):
  - last_id=1, so input 0 wins the first contention.
  - lock=0, FIFO empty, err_orphan=0.
  - Combinational outputs then follow: avl_m0.read=write=0 when inputs are idle; both avl_sN.readdatavalid=0.
  - Reset mid-transaction discards outstanding tags. Responses arriving after reset raise err_orphan.

Decomposition:
- Package avl_arb_pkg: typedef master_id_t (1-bit enum ID_ISTR=0, ID_DATA=1) and localparam TAG_CNT_W = $clog2(MAX_PENDING)+1.
- Sub-module avl_tag_fifo: synchronous FIFO with full/empty flags and a count; same clk/rest convention.
- Arbitration, lock and muxing stay in the top module.

Test Plan:
- Single read on s0 at 0x100 with slave latency 3 → one m0 read with address 0x100; s0.readdatavalid pulses exactly once with slave data; s1.readdatavalid stays 0.
- s0 and s1 both read every cycle for 8 cycles, waitrequest=0 → grants alternate 0,1,0,1…; first grant goes to s0 after reset; responses route to the matching master in order.
- s1 write held while m0.waitrequest=1 for 5 cycles and s0 raises read on cycle 2 → s1 keeps the grant (lock); the write is issued once; s0 is granted the cycle after acceptance.
- Slave withholds responses; 6 reads issued with MAX_PENDING=4 → exactly 4 accepted, then read_block keeps waitrequest=1 and m0.read=0; the first readdatavalid releases one slot in the following cycle.
- Inject m0.readdatavalid with no outstanding read → no master sees readdatavalid; err_orphan=1 and stays 1 until rest=0.
- Assert rest=0 for 2 cycles with 3 reads outstanding → FIFO empties and last_id=1; post-reset contention is granted to s0 first.
